ecc_point_add_ctrl: RTL

- Sequencer directly upstream of the GF(p) arithmetic unit (GFAU). Computes affine elliptic-curve point addition R = P + Q on y^2 = x^3 + a*x + b over GF(p).
- Issues one GFAU operation at a time (add/sub/mult/div) and stores intermediate results in a local temp register file.
- Resolves point-at-infinity and doubling cases internally, then returns R to the scalar-multiply layer above.

---
 rtl/ecc_point_add_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ecc_point_add_ctrl.sv
// Affine EC point-add sequencer: R = P + Q over GF(p), one GFAU op at a time.
// Optional ECC_OPCNT_EN adds o_op_cnt, a count of GFAU launches per request.
module ecc_point_add_ctrl #(
    parameter int unsigned SIZE = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [SIZE-1:0] i_prime,
    input  logic [SIZE-1:0] i_a,
    input  logic [SIZE-1:0] i_px,
    input  logic [SIZE-1:0] i_py,
    input  logic            i_p_inf,
    input  logic [SIZE-1:0] i_qx,
    input  logic [SIZE-1:0] i_qy,
    input  logic            i_q_inf,
    output logic            o_busy,
    output logic            o_done,
    output logic [SIZE-1:0] o_rx,
    output logic [SIZE-1:0] o_ry,
    output logic            o_r_inf,
    output logic            o_gf_go,
    output logic [1:0]      o_gf_op,
    output logic [SIZE-1:0] o_gf_in0,
    output logic [SIZE-1:0] o_gf_in1,
    output logic [SIZE-1:0] o_gf_prime,
`ifdef ECC_OPCNT_EN
    output logic [3:0]      o_op_cnt,
`endif
    input  logic            i_gf_done,
    input  logic [SIZE-1:0] i_gf_result
);

    typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_ISSUE, ST_WAIT, ST_FINISH} state_t;

    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;
    localparam logic [3:0] R_PX = 4'd0, R_PY = 4'd1, R_QX = 4'd2, R_QY = 4'd3, R_A = 4'd4;
    localparam logic [3:0] R_T0 = 4'd5, R_T1 = 4'd6, R_T2 = 4'd7, R_T3 = 4'd8, R_T4 = 4'd9;
    localparam logic [3:0] R_T5 = 4'd10, R_L = 4'd11, R_RX = 4'd12, R_RY = 4'd13;

    state_t          r_state;
    logic [SIZE-1:0] r_rf [16];
    logic [3:0]      r_step;
    logic            r_dbl;
    logic            r_inf;
    logic            r_p_inf;
    logic            r_q_inf;
    logic [3:0]      r_op_cnt;

    logic [3:0]      w_idx;
    logic [1:0]      w_op;
    logic [3:0]      w_s0, w_s1, w_dst;
    logic            w_last;

    // Doubling head lives at table rows 9..14; its tail reuses addition rows 3..8
    // because qx == px whenever doubling is selected.
    always_comb begin
        w_idx  = r_dbl ? ((r_step < 4'd6) ? r_step + 4'd9 : r_step - 4'd3) : r_step;
        w_last = r_dbl ? (r_step == 4'd11) : (r_step == 4'd8);
        w_op   = OP_ADD;
        w_s0   = R_PX;
        w_s1   = R_PX;
        w_dst  = R_T0;
        case (w_idx)
            4'd0:  begin w_op = OP_SUB; w_s0 = R_QY; w_s1 = R_PY; w_dst = R_T0; end
            4'd1:  begin w_op = OP_SUB; w_s0 = R_QX; w_s1 = R_PX; w_dst = R_T1; end
            4'd2:  begin w_op = OP_DIV; w_s0 = R_T0; w_s1 = R_T1; w_dst = R_L;  end
            4'd3:  begin w_op = OP_MUL; w_s0 = R_L;  w_s1 = R_L;  w_dst = R_T2; end
            4'd4:  begin w_op = OP_SUB; w_s0 = R_T2; w_s1 = R_PX; w_dst = R_T3; end
            4'd5:  begin w_op = OP_SUB; w_s0 = R_T3; w_s1 = R_QX; w_dst = R_RX; end
            4'd6:  begin w_op = OP_SUB; w_s0 = R_PX; w_s1 = R_RX; w_dst = R_T4; end
            4'd7:  begin w_op = OP_MUL; w_s0 = R_L;  w_s1 = R_T4; w_dst = R_T5; end
            4'd8:  begin w_op = OP_SUB; w_s0 = R_T5; w_s1 = R_PY; w_dst = R_RY; end
            4'd9:  begin w_op = OP_MUL; w_s0 = R_PX; w_s1 = R_PX; w_dst = R_T0; end
            4'd10: begin w_op = OP_ADD; w_s0 = R_T0; w_s1 = R_T0; w_dst = R_T1; end
            4'd11: begin w_op = OP_ADD; w_s0 = R_T1; w_s1 = R_T0; w_dst = R_T1; end
            4'd12: begin w_op = OP_ADD; w_s0 = R_T1; w_s1 = R_A;  w_dst = R_T1; end
            4'd13: begin w_op = OP_ADD; w_s0 = R_PY; w_s1 = R_PY; w_dst = R_T2; end
            4'd14: begin w_op = OP_DIV; w_s0 = R_T1; w_s1 = R_T2; w_dst = R_L;  end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_step     <= 4'd0;
            r_dbl      <= 1'b0;
            r_inf      <= 1'b0;
            r_p_inf    <= 1'b0;
            r_q_inf    <= 1'b0;
            r_op_cnt   <= 4'd0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_rx       <= '0;
            o_ry       <= '0;
            o_r_inf    <= 1'b0;
            o_gf_go    <= 1'b0;
            o_gf_op    <= 2'd0;
            o_gf_in0   <= '0;
            o_gf_in1   <= '0;
            o_gf_prime <= '0;
        end else begin
            o_done  <= 1'b0;
            o_gf_go <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_rf[R_PX] <= i_px;
                        r_rf[R_PY] <= i_py;
                        r_rf[R_QX] <= i_qx;
                        r_rf[R_QY] <= i_qy;
                        r_rf[R_A]  <= i_a;
                        r_p_inf    <= i_p_inf;
                        r_q_inf    <= i_q_inf;
                        o_gf_prime <= i_prime;
                        r_op_cnt   <= 4'd0;
                        o_busy     <= 1'b1;
                        r_state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_step <= 4'd0;
                    r_inf  <= 1'b0;
                    if (r_p_inf) begin
                        r_rf[R_RX] <= r_rf[R_QX];
                        r_rf[R_RY] <= r_rf[R_QY];
                        r_inf      <= r_q_inf;
                        r_state    <= ST_FINISH;
                    end else if (r_q_inf) begin
                        r_rf[R_RX] <= r_rf[R_PX];
                        r_rf[R_RY] <= r_rf[R_PY];
                        r_state    <= ST_FINISH;
                    end else if (r_rf[R_PX] == r_rf[R_QX] &&
                                 (r_rf[R_PY] != r_rf[R_QY] || r_rf[R_PY] == '0)) begin
                        r_inf   <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
                        r_dbl   <= (r_rf[R_PX] == r_rf[R_QX]);
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    o_gf_go  <= 1'b1;
                    o_gf_op  <= w_op;
                    o_gf_in0 <= r_rf[w_s0];
                    o_gf_in1 <= r_rf[w_s1];
                    r_op_cnt <= r_op_cnt + 4'd1;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_gf_done) begin
                        r_rf[w_dst] <= i_gf_result;
                        if (w_last) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_step  <= r_step + 4'd1;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_FINISH: begin
                    o_rx    <= r_inf ? '0 : r_rf[R_RX];
                    o_ry    <= r_inf ? '0 : r_rf[R_RY];
                    o_r_inf <= r_inf;
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ECC_OPCNT_EN
    assign o_op_cnt = r_op_cnt;
`endif

endmodule
